// File: rtl/fsm_transport_ctrl.sv
// rtl/fsm_transport_ctrl.sv - button debounce, play/pause short/long press and track navigation controller
module fsm_transport_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int LONG_PRESS_CYCLES = 40,
  parameter int NUM_TRACKS        = 8,
  parameter int TRACK_W           = 3,
  parameter int LOOP              = 0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_btn_play,
  input  logic               i_btn_next,
  input  logic               i_btn_prev,
  input  logic               i_track_end,
  output logic               o_saida,
  output logic [1:0]         o_state,
  output logic [TRACK_W-1:0] o_track,
  output logic               o_track_change
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [CW-1:0]      CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0]      HOLD_MAX   = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0]      HOLD_PRE   = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [TRACK_W-1:0] LAST_TRACK = TRACK_W'(NUM_TRACKS - 1);

  // bit 0 play, bit 1 next, bit 2 prev
  logic [2:0]         w_raw;
  logic [2:0]         r_btn_s;
  logic [2:0]         r_deb;
  logic [2:0]         r_deb_d;
  logic [CW-1:0]      r_cnt [3];
  logic [HW-1:0]      r_hold;
  logic               r_long;
  state_t             r_state;
  logic [TRACK_W-1:0] r_track;
  logic               r_track_change;
  logic               r_saida;

  logic               w_next_evt;
  logic               w_prev_evt;
  logic               w_short;
  logic               w_end_stop;
  state_t             w_state_nx;
  logic [TRACK_W-1:0] w_track_nx;

  assign w_raw = {i_btn_prev, i_btn_next, i_btn_play};

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_btn_s <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
      r_hold  <= '0;
      r_long  <= 1'b0;
    end else begin
      r_btn_s <= w_raw;
      r_deb_d <= r_deb;
      for (int i = 0; i < 3; i++) begin
        if (r_btn_s[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_deb[i] <= r_btn_s[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
      if (!r_deb[0]) r_hold <= '0;
      else if (r_hold != HOLD_MAX) r_hold <= r_hold + 1'b1;
      // saturation keeps this to a single pulse per hold
      r_long <= r_deb[0] && (r_hold == HOLD_PRE);
    end
  end

  assign w_next_evt = r_deb[1] & ~r_deb_d[1];
  assign w_prev_evt = r_deb[2] & ~r_deb_d[2];
  assign w_short    = ~r_deb[0] & r_deb_d[0] & (r_hold != HOLD_MAX);

  always_comb begin
    w_track_nx = r_track;
    w_state_nx = r_state;
    w_end_stop = 1'b0;
    if (w_next_evt && !w_prev_evt) begin
      w_track_nx = (r_track == LAST_TRACK) ? '0 : r_track + 1'b1;
    end else if (w_prev_evt && !w_next_evt) begin
      w_track_nx = (r_track == '0) ? LAST_TRACK : r_track - 1'b1;
    end else if (!w_next_evt && !w_prev_evt && i_track_end && r_state == ST_PLAY) begin
      if (r_track == LAST_TRACK) begin
        w_track_nx = '0;
        w_end_stop = (LOOP == 0);
      end else begin
        w_track_nx = r_track + 1'b1;
      end
    end
    if (r_long || w_end_stop) begin
      w_state_nx = ST_STOP;
    end else if (w_short) begin
      case (r_state)
        ST_STOP:  w_state_nx = ST_PLAY;
        ST_PLAY:  w_state_nx = ST_PAUSE;
        ST_PAUSE: w_state_nx = ST_PLAY;
        default:  w_state_nx = ST_STOP;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state        <= ST_STOP;
      r_track        <= '0;
      r_track_change <= 1'b0;
      r_saida        <= 1'b0;
    end else begin
      r_state        <= w_state_nx;
      r_track        <= w_track_nx;
      r_track_change <= (w_track_nx != r_track);
      r_saida        <= (w_state_nx == ST_PLAY);
    end
  end

  assign o_state        = r_state;
  assign o_track        = r_track;
  assign o_track_change = r_track_change;
  assign o_saida        = r_saida;

endmodule

// File: tb/tb_fsm_transport_ctrl.sv
// tb/tb_fsm_transport_ctrl.sv - directed bench for fsm_transport_ctrl (LOOP=0 and LOOP=1 instances)
module tb_fsm_transport_ctrl;

  logic       clk = 1'b0;
  logic       reset, bp, bn, bv, te;
  logic       sa_a, tc_a, sa_b, tc_b;
  logic [1:0] st_a, st_b;
  logic [2:0] tr_a, tr_b;
  logic [6:0] obs_a, obs_b, e;
  int         n_checks = 0;
  int         n_errors = 0;

  // observation vector: {state, saida, track, track_change}
  assign obs_a = {st_a, sa_a, tr_a, tc_a};
  assign obs_b = {st_b, sa_b, tr_b, tc_b};

  always #5 clk = ~clk;

  fsm_transport_ctrl #(.LOOP(0)) dut_a (
    .i_clk(clk), .i_reset(reset), .i_btn_play(bp), .i_btn_next(bn), .i_btn_prev(bv),
    .i_track_end(te), .o_saida(sa_a), .o_state(st_a), .o_track(tr_a), .o_track_change(tc_a)
  );

  fsm_transport_ctrl #(.LOOP(1)) dut_b (
    .i_clk(clk), .i_reset(reset), .i_btn_play(bp), .i_btn_next(bn), .i_btn_prev(bv),
    .i_track_end(te), .o_saida(sa_b), .o_state(st_b), .o_track(tr_b), .o_track_change(tc_b)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_play(input int n);
    bp = 1'b1;
    cyc(n);
    bp = 1'b0;
    cyc(10);
  endtask

  task automatic do_nav(input logic is_next, input logic [2:0] old_t, input logic [2:0] new_t);
    if (is_next) bn = 1'b1; else bv = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      n_checks++;
      if ({tr_a, tc_a} !== {old_t, 1'b0}) begin
        n_errors++; $display("FAIL nav_early cyc=%0d got=%b exp=%b", i, {tr_a, tc_a}, {old_t, 1'b0});
      end
    end
    cyc(1);
    n_checks++;
    if ({tr_a, tc_a} !== {new_t, 1'b1}) begin
      n_errors++; $display("FAIL nav_update got=%b exp=%b", {tr_a, tc_a}, {new_t, 1'b1});
    end
    cyc(1);
    n_checks++;
    if ({tr_a, tc_a} !== {new_t, 1'b0}) begin
      n_errors++; $display("FAIL nav_pulse_end got=%b exp=%b", {tr_a, tc_a}, {new_t, 1'b0});
    end
    bn = 1'b0; bv = 1'b0;
    cyc(8);
  endtask

  task automatic test_reset;
    reset = 1'b0; bp = 1'b0; bn = 1'b0; bv = 1'b0; te = 1'b0;
    cyc(2);
    e = 7'b0000000;
    n_checks++;
    if (obs_a !== e) begin n_errors++; $display("FAIL reset_a got=%b exp=%b", obs_a, e); end
    n_checks++;
    if (obs_b !== e) begin n_errors++; $display("FAIL reset_b got=%b exp=%b", obs_b, e); end
    reset = 1'b1;
    cyc(1);
  endtask

  task automatic test_short_press;
    bp = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      n_checks++;
      if (obs_a !== 7'b0000000) begin n_errors++; $display("FAIL held_no_change cyc=%0d got=%b exp=%b", i, obs_a, 7'b0000000); end
    end
    bp = 1'b0;
    cyc(5);
    n_checks++;
    if (obs_a !== 7'b0000000) begin n_errors++; $display("FAIL release_early got=%b exp=%b", obs_a, 7'b0000000); end
    cyc(1);
    e = {2'b01, 1'b1, 3'd0, 1'b0};
    n_checks++;
    if (obs_a !== e) begin n_errors++; $display("FAIL stop_to_play got=%b exp=%b", obs_a, e); end
    cyc(4);
    bp = 1'b1;
    cyc(10);
    bp = 1'b0;
    cyc(5);
    n_checks++;
    if (obs_a !== e) begin n_errors++; $display("FAIL play_before_pause got=%b exp=%b", obs_a, e); end
    cyc(1);
    e = {2'b10, 1'b0, 3'd0, 1'b0};
    n_checks++;
    if (obs_a !== e) begin n_errors++; $display("FAIL play_to_pause got=%b exp=%b", obs_a, e); end
    cyc(4);
  endtask

  task automatic test_glitch;
    bn = 1'b1;
    cyc(2);
    bn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      n_checks++;
      if ({tr_a, tc_a} !== 4'b0000) begin n_errors++; $display("FAIL glitch cyc=%0d got=%b exp=%b", i, {tr_a, tc_a}, 4'b0000); end
    end
  endtask

  task automatic test_navigation;
    do_nav(1'b1, 3'd0, 3'd1);
    do_nav(1'b1, 3'd1, 3'd2);
    do_nav(1'b1, 3'd2, 3'd3);
    do_nav(1'b0, 3'd3, 3'd2);
    do_nav(1'b0, 3'd2, 3'd1);
    do_nav(1'b0, 3'd1, 3'd0);
    do_nav(1'b0, 3'd0, 3'd7);
  endtask

  task automatic test_track_end;
    te = 1'b1; cyc(1); te = 1'b0;
    e = {2'b10, 1'b0, 3'd7, 1'b0};
    n_checks++;
    if (obs_a !== e) begin n_errors++; $display("FAIL end_in_pause got=%b exp=%b", obs_a, e); end
    cyc(2);
    press_play(8);
    e = {2'b01, 1'b1, 3'd7, 1'b0};
    n_checks++;
    if (obs_a !== e) begin n_errors++; $display("FAIL resume_play got=%b exp=%b", obs_a, e); end
    te = 1'b1; cyc(1); te = 1'b0;
    e = {2'b00, 1'b0, 3'd0, 1'b1};
    n_checks++;
    if (obs_a !== e) begin n_errors++; $display("FAIL last_end_noloop got=%b exp=%b", obs_a, e); end
    e = {2'b01, 1'b1, 3'd0, 1'b1};
    n_checks++;
    if (obs_b !== e) begin n_errors++; $display("FAIL last_end_loop got=%b exp=%b", obs_b, e); end
    cyc(1);
    e = {2'b00, 1'b0, 3'd0, 1'b0};
    n_checks++;
    if (obs_a !== e) begin n_errors++; $display("FAIL end_pulse_width got=%b exp=%b", obs_a, e); end
    te = 1'b1; cyc(1); te = 1'b0;
    n_checks++;
    if (obs_a !== e) begin n_errors++; $display("FAIL end_in_stop got=%b exp=%b", obs_a, e); end
    e = {2'b01, 1'b1, 3'd1, 1'b1};
    n_checks++;
    if (obs_b !== e) begin n_errors++; $display("FAIL mid_end_advance got=%b exp=%b", obs_b, e); end
    cyc(2);
  endtask

  task automatic test_long_press;
    press_play(8);
    e = {2'b01, 1'b1, 3'd0, 1'b0};
    n_checks++;
    if (obs_a !== e) begin n_errors++; $display("FAIL pre_long_play got=%b exp=%b", obs_a, e); end
    bp = 1'b1;
    cyc(45);
    n_checks++;
    if (obs_a !== e) begin n_errors++; $display("FAIL long_early got=%b exp=%b", obs_a, e); end
    cyc(1);
    e = {2'b00, 1'b0, 3'd0, 1'b0};
    n_checks++;
    if (obs_a !== e) begin n_errors++; $display("FAIL long_to_stop got=%b exp=%b", obs_a, e); end
    e = {2'b00, 1'b0, 3'd1, 1'b0};
    n_checks++;
    if (obs_b !== e) begin n_errors++; $display("FAIL long_from_pause got=%b exp=%b", obs_b, e); end
    cyc(14);
    bp = 1'b0;
    cyc(10);
    e = {2'b00, 1'b0, 3'd0, 1'b0};
    n_checks++;
    if (obs_a !== e) begin n_errors++; $display("FAIL long_release got=%b exp=%b", obs_a, e); end
  endtask

  task automatic test_simultaneous_nav;
    bn = 1'b1; bv = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      n_checks++;
      if ({tr_a, tc_a} !== 4'b0000) begin n_errors++; $display("FAIL nav_cancel cyc=%0d got=%b exp=%b", i, {tr_a, tc_a}, 4'b0000); end
    end
    bn = 1'b0; bv = 1'b0;
    cyc(8);
  endtask

  task automatic test_reset_mid_hold;
    press_play(8);
    do_nav(1'b1, 3'd0, 3'd1);
    bp = 1'b1;
    cyc(30);
    e = {2'b01, 1'b1, 3'd1, 1'b0};
    n_checks++;
    if (obs_a !== e) begin n_errors++; $display("FAIL hold_30 got=%b exp=%b", obs_a, e); end
    reset = 1'b0;
    cyc(2);
    e = 7'b0000000;
    n_checks++;
    if (obs_a !== e) begin n_errors++; $display("FAIL midhold_reset got=%b exp=%b", obs_a, e); end
    reset = 1'b1;
    cyc(20);
    bp = 1'b0;
    cyc(5);
    n_checks++;
    if (obs_a !== e) begin n_errors++; $display("FAIL rehold_early got=%b exp=%b", obs_a, e); end
    cyc(1);
    e = {2'b01, 1'b1, 3'd0, 1'b0};
    n_checks++;
    if (obs_a !== e) begin n_errors++; $display("FAIL rehold_short got=%b exp=%b", obs_a, e); end
  endtask

  initial begin
    test_reset;
    test_short_press;
    test_glitch;
    test_navigation;
    test_track_end;
    test_long_press;
    test_simultaneous_nav;
    test_reset_mid_hold;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fsm_transport_ctrl.md
# fsm_transport_ctrl

Parametrised transport controller for the music player: debounces three raw push-buttons (play/pause, next, prev), detects short and long presses on play/pause, and keeps the player state (STOP/PLAY/PAUSE) and the current track index. It sits between the board buttons and the tone/sequencer blocks. It supersedes the single-button play/pause toggle by adding debounce, a stop state, track navigation and end-of-track handling.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable samples required before a debounced level changes (≥1).
- LONG_PRESS_CYCLES, 40: debounced-high cycles on btn_play that constitute a long press (≥2).
- NUM_TRACKS, 8: number of tracks; track index range 0..NUM_TRACKS-1 (≥1).
- TRACK_W, 3: width of track output; must satisfy 2^TRACK_W ≥ NUM_TRACKS.
- LOOP, 0: 1 = wrap to track 0 and keep playing after the last track ends; 0 = stop at track 0.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- btn_play  in  1  raw play/pause button, active high.
- btn_next  in  1  raw next-track button, active high.
- btn_prev  in  1  raw previous-track button, active high.
- track_end  in  1  one-cycle pulse from the sequencer: current track finished.
- saida  out  1  1 while state is PLAY.
- state  out  2  00 STOP, 01 PLAY, 10 PAUSE (11 unused, never driven).
- track  out  TRACK_W  current track index.
- track_change  out  1  one-cycle pulse in the first cycle a new track value is visible.

## Operation
- Per button: input flop btn_s, debounced level deb, counter. Counter clears whenever btn_s == deb; else increments; when it would reach DEBOUNCE_CYCLES, deb <= btn_s and counter clears.
- next/prev event: deb rising edge. play events: hold counter (width $clog2(LONG_PRESS_CYCLES+1)) clears while deb_play = 0, increments while 1, saturates at LONG_PRESS_CYCLES.
  - Long press: hold counter goes LONG_PRESS_CYCLES-1 → LONG_PRESS_CYCLES; fires once per hold.
  - Short press: deb_play falls with hold counter < LONG_PRESS_CYCLES. Release after a long press generates nothing.
- State transitions: short press STOP→PLAY, PLAY→PAUSE, PAUSE→PLAY. Long press from any state → STOP (STOP stays STOP). Track is unchanged by play events.
- Track events (any state): next → (track+1) mod NUM_TRACKS; prev → track 0 goes to NUM_TRACKS-1, else track-1.
- track_end honoured only in PLAY: track < NUM_TRACKS-1 → track+1, stay PLAY; track = NUM_TRACKS-1 → track 0, state PLAY if LOOP=1 else STOP.
- Priority / simultaneity:
  - next and prev events in the same cycle cancel: no track change, no pulse.
  - A next/prev event in the same cycle as track_end wins; that track_end is dropped.
  - Play events and track events in the same cycle both apply. A track_end coinciding with a long press still moves the track, but state ends STOP.
- track_change asserts only if the track value actually differs (NUM_TRACKS=1 never pulses).

## Timing
- Reset (reset=0 at a rising edge): state=00, saida=0, track=0, track_change=0, all btn_s/deb/counters 0. Applies mid-debounce or mid-hold; a button still held after reset release is debounced afresh as a new press.
- Raw edge sampled at edge E0 (btn_s updates). deb changes at edge E0+DEBOUNCE_CYCLES if the level stays stable. State/track/saida update at edge E0+DEBOUNCE_CYCLES+1.
- Glitches shorter than DEBOUNCE_CYCLES samples are ignored.
- Long press: state becomes STOP one edge after the hold counter reaches LONG_PRESS_CYCLES, i.e. LONG_PRESS_CYCLES+1 edges after deb_play rises.
- track_end response: registered, visible the edge after the pulse is sampled. track_change is high exactly that one cycle.
- saida is registered, equal to (state==01) in every cycle.

## Test plan
- Reset held low 2 edges → state=00, track=0, saida=0, track_change=0. Then btn_play high 10 cycles, low: no change while held; state=01, saida=1 DEBOUNCE_CYCLES+1 edges after release; repeat press → state=10, saida=0.
- 2-cycle pulse on btn_next (DEBOUNCE_CYCLES=4) → track stays 0, no track_change.
- Three clean next presses → track 3, three single-cycle track_change pulses. Four prev presses → 2,1,0,7.
- In PLAY, hold btn_play 60 cycles → state=00 at LONG_PRESS_CYCLES+1 edges after deb rise; release → stays 00, saida=0.
- PLAY at track 7: track_end → LOOP=0: state=00, track=0, one pulse; LOOP=1: state=01, track=0. In PAUSE, track_end → no change.
- btn_next and btn_prev rise on the same edge → track unchanged, no pulse. reset=0 during a 30-cycle play hold → STOP, track 0, no later long-press event unless re-held 40+ cycles.
